msk_and_hpc2_pipe: RTL and testbench

MSK_AND_HPC2_PIPE -- requirements
Module: msk_and_hpc2_pipe

---
 rtl/msk_and_hpc2_pipe.sv | 141 ++++++++++++++
 tb/tb_msk_and_hpc2_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_hpc2_pipe.sv
// Two-stage HPC2 masked AND over W independent bit lanes, each split into D Boolean shares.
// Handshake: a transfer occurs on a rising edge where valid and ready are both high; operands and randomness move together.
module msk_and_hpc2_pipe #(
  parameter int D = 2,
  parameter int W = 8,
  localparam int NR  = D*(D-1)/2,
  localparam int NRT = W*NR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D*W-1:0] ina,
  input  logic [D*W-1:0] inb,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [NRT-1:0] rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*W-1:0] out
);

  // Lane-local index of the random bit shared by share pair (i,j), i != j.
  function automatic int ridx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo*D - lo*(lo+1)/2 + (hi-1-lo);
  endfunction

  logic                       r_s1_valid;
  logic [W-1:0][D-1:0]        r_s1_a;
  logic [W-1:0][D-1:0]        r_s1_b;
  logic [NRT-1:0]             r_s1_rnd;
  logic [W-1:0][D-1:0][D-1:0] r_s1_v;

  logic                       r_s2_valid;
  logic [W-1:0][D-1:0]        r_s2_aibi;
  logic [W-1:0][D-1:0][D-1:0] r_s2_u;
  logic [W-1:0][D-1:0][D-1:0] r_s2_w;

  logic                       w_s2_free;
  logic                       w_s1_free;
  logic                       w_accept;
  logic                       w_s1_move;
  logic [W-1:0][D-1:0]        w_in_a;
  logic [W-1:0][D-1:0]        w_in_b;
  logic [W-1:0][D-1:0][D-1:0] w_in_v;
  logic [W-1:0][D-1:0]        w_aibi;
  logic [W-1:0][D-1:0][D-1:0] w_u;
  logic [W-1:0][D-1:0][D-1:0] w_w;

  assign w_s2_free = ~r_s2_valid | out_ready;
  assign w_s1_free = ~r_s1_valid | w_s2_free;
  assign w_accept  = in_valid & rnd_valid & w_s1_free;
  assign w_s1_move = r_s1_valid & w_s2_free;

  // Readies are forced low while rst is held so nothing is offered as taken.
  assign in_ready  = rnd_valid & w_s1_free & ~rst;
  assign rnd_ready = in_valid & w_s1_free & ~rst;
  assign out_valid = r_s2_valid;

  always_comb begin
    w_in_a = '0;
    w_in_b = '0;
    w_in_v = '0;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < D; i++) begin
        w_in_a[b][i] = ina[i*W+b];
        w_in_b[b][i] = inb[i*W+b];
        for (int j = 0; j < D; j++) begin
          if (j != i) w_in_v[b][i][j] = inb[j*W+b] ^ rnd[b*NR + ridx(i, j)];
        end
      end
    end
  end

  // Stage-2 terms are built only from stage-1 registers to keep shares from recombining early.
  always_comb begin
    w_aibi = '0;
    w_u    = '0;
    w_w    = '0;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < D; i++) begin
        w_aibi[b][i] = r_s1_a[b][i] & r_s1_b[b][i];
        for (int j = 0; j < D; j++) begin
          if (j != i) begin
            w_u[b][i][j] = ~r_s1_a[b][i] & r_s1_rnd[b*NR + ridx(i, j)];
            w_w[b][i][j] = r_s1_a[b][i] & r_s1_v[b][i][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_rnd   <= '0;
      r_s1_v     <= '0;
    end else begin
      r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_free);
      if (w_accept) begin
        r_s1_a   <= w_in_a;
        r_s1_b   <= w_in_b;
        r_s1_rnd <= rnd;
        r_s1_v   <= w_in_v;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_aibi  <= '0;
      r_s2_u     <= '0;
      r_s2_w     <= '0;
    end else begin
      r_s2_valid <= w_s1_move | (r_s2_valid & ~out_ready);
      if (w_s1_move) begin
        r_s2_aibi <= w_aibi;
        r_s2_u    <= w_u;
        r_s2_w    <= w_w;
      end
    end
  end

  // Diagonal u/w entries are held at zero, so a full-row XOR covers exactly j != i.
  always_comb begin
    out = '0;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < D; i++) begin
        out[i*W+b] = r_s2_aibi[b][i] ^ (^r_s2_u[b][i]) ^ (^r_s2_w[b][i]);
      end
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Bench for msk_and_hpc2_pipe: exact-share vectors on a D=2/W=1 instance, handshake and
// unmasked-result checks on a D=3/W=8 instance through an in-order expected queue.
module tb_msk_and_hpc2_pipe;
  localparam int D   = 3;
  localparam int W   = 8;
  localparam int DW  = D*W;
  localparam int NRT = W*D*(D-1)/2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- D=3, W=8 instance ----------------
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  ina       = '0;
  logic [DW-1:0]  inb       = '0;
  logic           rnd_valid = 1'b0;
  logic           rnd_ready;
  logic [NRT-1:0] rnd       = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out;

  msk_and_hpc2_pipe #(.D(D), .W(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .ina(ina), .inb(inb),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  // ---------------- D=2, W=1 instance ----------------
  logic       s_in_valid  = 1'b0;
  logic       s_in_ready;
  logic [1:0] s_ina       = '0;
  logic [1:0] s_inb       = '0;
  logic       s_rnd_valid = 1'b0;
  logic       s_rnd_ready;
  logic [0:0] s_rnd       = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b1;
  logic [1:0] s_out;

  msk_and_hpc2_pipe #(.D(2), .W(1)) u_dut_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .ina(s_ina), .inb(s_inb),
    .rnd_valid(s_rnd_valid), .rnd_ready(s_rnd_ready), .rnd(s_rnd),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] unmask(input logic [DW-1:0] x);
    logic [W-1:0] acc;
    acc = '0;
    for (int s = 0; s < D; s++) acc ^= x[s*W +: W];
    return acc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_op(input logic [W-1:0] ua, input logic [W-1:0] ub);
    logic [W-1:0] m1, m2, n1, n2;
    m1 = W'($urandom);
    m2 = W'($urandom);
    n1 = W'($urandom);
    n2 = W'($urandom);
    ina = {m2, m1, ua ^ m1 ^ m2};
    inb = {n2, n1, ub ^ n1 ^ n2};
    rnd = NRT'($urandom);
  endtask

  task automatic run_small(input logic [1:0] a, input logic [1:0] b, input logic r,
                           input logic [1:0] e);
    @(posedge clk); #1;
    s_ina = a; s_inb = b; s_rnd = r; s_in_valid = 1'b1; s_rnd_valid = 1'b1;
    @(negedge clk);
    check("small_accept", 32'(s_in_ready), 32'd1);
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_rnd_valid = 1'b0;
    @(negedge clk);
    check("small_lat1", 32'(s_out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("small_lat2", 32'(s_out_valid), 32'd1);
    check("small_shares", 32'(s_out), 32'(e));
    check("small_unmask", 32'(s_out[0] ^ s_out[1]), 32'((a[0] ^ a[1]) & (b[0] ^ b[1])));
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  int in_hs  = 0;
  int rnd_hs = 0;
  int out_hs = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(unmask(ina) & unmask(inb));
        in_hs++;
      end
      if (rnd_valid && rnd_ready) rnd_hs++;
      if (out_valid && out_ready) begin
        out_hs++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          sb_exp = exp_q.pop_front();
          check("sb_data", 32'(unmask(out)), 32'(sb_exp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int bp_rdy [5] = '{1, 1, 0, 0, 1};
  int sent;
  logic got;
  int cyc;
  int target;

  initial begin
    // Reset state with valids offered.
    in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1; s_in_valid = 1'b1; s_rnd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    check("rst_small_in_ready", 32'(s_in_ready), 32'd0);
    in_valid = 1'b0; rnd_valid = 1'b0; s_in_valid = 1'b0; s_rnd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Exact-share vectors, D=2 W=1.
    run_small(2'b01, 2'b10, 1'b1, 2'b10);
    run_small(2'b11, 2'b01, 1'b0, 2'b11);
    run_small(2'b10, 2'b11, 1'b1, 2'b11);

    // Back-pressure: three back-to-back ops with out_ready low for four cycles.
    out_ready = 1'b0;
    sent = 0;
    @(posedge clk); #1;
    load_op(8'hF0, 8'h3C); in_valid = 1'b1; rnd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(bp_rdy[c]));
      if (c >= 2) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_out", 32'(unmask(out)), 32'h30);
      end
      got = in_ready;
      @(posedge clk); #1;
      if (got) begin
        sent++;
        if (sent == 1)      load_op(8'hAA, 8'h0F);
        else if (sent == 2) load_op(8'h55, 8'hFF);
        else begin in_valid = 1'b0; rnd_valid = 1'b0; end
      end
      if (c == 3) out_ready = 1'b1;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_sent", 32'(sent), 32'd3);

    // Full throughput: four consecutive accepts and four consecutive results.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      load_op(W'(8'h13 * (k + 1)), W'(8'hE7 - k));
      in_valid = 1'b1; rnd_valid = 1'b1;
      @(negedge clk);
      check("tp_in_ready", 32'(in_ready), 32'd1);
      if (k >= 2) check("tp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rnd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("tp_tail_valid", 32'(out_valid), 32'(k < 2));
    end

    // Randomness starvation with one op in flight.
    @(posedge clk); #1;
    load_op(8'hC3, 8'h81); in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check("starve_first_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    load_op(8'h7E, 8'h7E); rnd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("starve_in_ready", 32'(in_ready), 32'd0);
      check("starve_rnd_ready", 32'(rnd_ready), 32'd1);
      check("starve_out_valid", 32'(out_valid), 32'(c == 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Reset the cycle after an accept, then a fresh op.
    @(posedge clk); #1;
    load_op(8'hFF, 8'hFF); in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check("mrst_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_after_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    load_op(8'h96, 8'h5A); in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check("mrst_fresh_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    @(negedge clk);
    check("mrst_lat1", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mrst_lat2", 32'(out_valid), 32'd1);
    check("mrst_data", 32'(unmask(out)), 32'h12);

    // Random operands with random stalls on all three handshakes.
    cyc = 0;
    target = in_hs + 2000;
    while (in_hs < target && cyc < 20000) begin
      @(posedge clk); #1;
      load_op(W'($urandom), W'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
      @(negedge clk);
    end
    check("rand_budget", 32'(in_hs >= target), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    // Final report.
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_hs_balance", 32'(rnd_hs), 32'(in_hs));
    check("final_out_valid", 32'(out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
